// File: rtl/result_accumulator.sv
// Batch accumulator for 3-bit adder results: sums NUM_SAMPLES results, then holds
// the wrapped sum with a sticky overflow flag until downstream acknowledges it.
module result_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_WIDTH   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [2:0]           i_result,
  output logic                 o_ready,
  input  logic                 i_clear,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_sum_valid,
  input  logic                 i_sum_ack,
  output logic                 o_overflow,
  output logic [7:0]           o_count
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

  state_t               state_r;
  state_t               state_next_s;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] sum_r;
  logic                 ovf_r;
  logic [7:0]           count_r;
  logic                 accept_s;
  logic                 last_s;
  logic [ACC_WIDTH:0]   add_s;

  // Sample acceptance and the carry-extended running sum.
  always_comb begin
    accept_s = i_valid && (state_r == ST_ACCUM);
    last_s   = accept_s && (count_r == LAST_IDX);
    add_s    = {1'b0, acc_r} + {{(ACC_WIDTH-2){1'b0}}, i_result};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; clear overrides both completion and acknowledge.
  always_comb begin
    state_next_s = state_r;
    if (i_clear) begin
      state_next_s = ST_ACCUM;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (last_s) state_next_s = ST_HOLD;
          else        state_next_s = ST_ACCUM;
        end
        ST_HOLD: begin
          if (i_sum_ack) state_next_s = ST_ACCUM;
          else           state_next_s = ST_HOLD;
        end
        default: state_next_s = ST_ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    o_ready     = 1'b1;
    o_sum_valid = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        o_ready     = 1'b1;
        o_sum_valid = 1'b0;
      end
      ST_HOLD: begin
        o_ready     = 1'b0;
        o_sum_valid = 1'b1;
      end
      default: begin
        o_ready     = 1'b1;
        o_sum_valid = 1'b0;
      end
    endcase
  end

  // Accumulator, count, sticky overflow and the presented sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r   <= {ACC_WIDTH{1'b0}};
      sum_r   <= {ACC_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      count_r <= 8'd0;
    end else if (i_clear) begin
      acc_r   <= {ACC_WIDTH{1'b0}};
      sum_r   <= {ACC_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r   <= add_s[ACC_WIDTH-1:0];
            ovf_r   <= ovf_r | add_s[ACC_WIDTH];
            count_r <= count_r + 8'd1;
            // sum_r stays zero while collecting so o_sum reads 0 outside HOLD
            if (last_s) sum_r <= add_s[ACC_WIDTH-1:0];
            else        sum_r <= sum_r;
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_HOLD: begin
          if (i_sum_ack) begin
            acc_r   <= {ACC_WIDTH{1'b0}};
            sum_r   <= {ACC_WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            count_r <= 8'd0;
          end else begin
            acc_r <= acc_r;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign o_sum      = sum_r;
  assign o_overflow = ovf_r;
  assign o_count    = count_r;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator: three instances cover the default
// configuration, a 4-bit accumulator for overflow, and single-sample batches.
module tb_result_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  int   pulses = 0;
  int   pulse_base;

  always #5 clk = ~clk;

  // u0: NUM_SAMPLES=4, ACC_WIDTH=8
  logic v0 = 1'b0, c0 = 1'b0, a0 = 1'b0, rdy0, sv0, ov0;
  logic [2:0] r0 = 3'd0;
  logic [7:0] s0, n0;
  // u1: NUM_SAMPLES=4, ACC_WIDTH=4
  logic v1 = 1'b0, c1 = 1'b0, a1 = 1'b0, rdy1, sv1, ov1;
  logic [2:0] r1 = 3'd0;
  logic [3:0] s1;
  logic [7:0] n1;
  // u2: NUM_SAMPLES=1, ACC_WIDTH=8
  logic v2 = 1'b0, c2 = 1'b0, a2 = 1'b0, rdy2, sv2, ov2;
  logic [2:0] r2 = 3'd0;
  logic [7:0] s2, n2;

  result_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(8)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .i_result(r0), .o_ready(rdy0),
    .i_clear(c0), .o_sum(s0), .o_sum_valid(sv0), .i_sum_ack(a0),
    .o_overflow(ov0), .o_count(n0));
  result_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_result(r1), .o_ready(rdy1),
    .i_clear(c1), .o_sum(s1), .o_sum_valid(sv1), .i_sum_ack(a1),
    .o_overflow(ov1), .o_count(n1));
  result_accumulator #(.NUM_SAMPLES(1), .ACC_WIDTH(8)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .i_result(r2), .o_ready(rdy2),
    .i_clear(c2), .o_sum(s2), .o_sum_valid(sv2), .i_sum_ack(a2),
    .o_overflow(ov2), .o_count(n2));

  always @(posedge clk) if (sv0) pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state, independent of the clock
    #2;
    chk("rst_count", 32'(n0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_sum_valid", 32'(sv0), 32'd0);
    chk("rst_sum", 32'(s0), 32'd0);
    chk("rst_ovf", 32'(ov0), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Basic batch 7,7,7,7
    v0 = 1'b1; r0 = 3'd7;
    step(); step(); step();
    chk("basic_count3", 32'(n0), 32'd3);
    chk("basic_sv_early", 32'(sv0), 32'd0);
    chk("basic_sum_accum", 32'(s0), 32'd0);
    step();
    chk("basic_sum", 32'(s0), 32'd28);
    chk("basic_ovf", 32'(ov0), 32'd0);
    chk("basic_count", 32'(n0), 32'd4);
    chk("basic_sv", 32'(sv0), 32'd1);
    chk("basic_ready", 32'(rdy0), 32'd0);

    // Backpressure: samples offered while holding are ignored
    r0 = 3'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sum_stable", 32'(s0), 32'd28);
      chk("bp_count_stable", 32'(n0), 32'd4);
      chk("bp_sv_held", 32'(sv0), 32'd1);
    end
    a0 = 1'b1; v0 = 1'b0;
    step();
    a0 = 1'b0;
    chk("ack_sv", 32'(sv0), 32'd0);
    chk("ack_count", 32'(n0), 32'd0);
    chk("ack_sum", 32'(s0), 32'd0);
    v0 = 1'b1; r0 = 3'd3;
    step();
    a0 = 1'b1;
    step();
    a0 = 1'b0;
    chk("ack_in_accum", 32'(n0), 32'd2);
    step(); step();
    chk("bp_sum12", 32'(s0), 32'd12);
    chk("bp_sv12", 32'(sv0), 32'd1);
    v0 = 1'b0; a0 = 1'b1;
    step();
    a0 = 1'b0;

    // Clear mid-batch, clear wins over a coincident sample
    v0 = 1'b1; r0 = 3'd5;
    step();
    r0 = 3'd6;
    step();
    chk("clr_pre_count", 32'(n0), 32'd2);
    r0 = 3'd7; c0 = 1'b1;
    step();
    c0 = 1'b0;
    chk("clr_count", 32'(n0), 32'd0);
    chk("clr_ready", 32'(rdy0), 32'd1);
    r0 = 3'd1;
    step(); step(); step(); step();
    chk("clr_sum4", 32'(s0), 32'd4);
    chk("clr_sv4", 32'(sv0), 32'd1);
    v0 = 1'b0; c0 = 1'b1;
    step();
    c0 = 1'b0;
    chk("clr_hold_sv", 32'(sv0), 32'd0);
    chk("clr_hold_sum", 32'(s0), 32'd0);

    // Overflow in a 4-bit accumulator: 7,7,7,0 -> 21 mod 16 = 5
    v1 = 1'b1; r1 = 3'd7;
    step(); step(); step();
    chk("ovf_sticky", 32'(ov1), 32'd1);
    chk("ovf_count3", 32'(n1), 32'd3);
    r1 = 3'd0;
    step();
    chk("ovf_sum", 32'(s1), 32'd5);
    chk("ovf_flag", 32'(ov1), 32'd1);
    chk("ovf_sv", 32'(sv1), 32'd1);
    v1 = 1'b0; a1 = 1'b1;
    step();
    a1 = 1'b0;
    chk("ovf_ack_flag", 32'(ov1), 32'd0);
    chk("ovf_ack_count", 32'(n1), 32'd0);

    // Single-sample batches: 6, ack (coincident sample refused), 3
    v2 = 1'b1; r2 = 3'd6;
    step();
    chk("ns1_sv6", 32'(sv2), 32'd1);
    chk("ns1_sum6", 32'(s2), 32'd6);
    r2 = 3'd3; a2 = 1'b1;
    step();
    a2 = 1'b0;
    chk("ns1_ack_sv", 32'(sv2), 32'd0);
    chk("ns1_ack_count", 32'(n2), 32'd0);
    step();
    chk("ns1_sv3", 32'(sv2), 32'd1);
    chk("ns1_sum3", 32'(s2), 32'd3);
    v2 = 1'b0;

    // Gaps then asynchronous reset mid-batch
    pulse_base = pulses;
    v0 = 1'b1; r0 = 3'd2; step();
    v0 = 1'b0; step();
    v0 = 1'b1; r0 = 3'd1; step();
    v0 = 1'b0; step();
    v0 = 1'b1; r0 = 3'd4; step();
    v0 = 1'b0;
    chk("gap_count", 32'(n0), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(n0), 32'd0);
    chk("arst_ready", 32'(rdy0), 32'd1);
    step(); step();
    rst_n = 1'b1;
    v0 = 1'b1; r0 = 3'd5;
    step();
    v0 = 1'b0;
    chk("post_rst_accept", 32'(n0), 32'd1);
    chk("no_sv_pulse", 32'(pulses - pulse_base), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 Parameter NUM_SAMPLES, default 4, is the number of adder results summed per batch; legal range 1..255.
REQ-002 Parameter ACC_WIDTH, default 8, is the accumulator and sum width in bits; legal minimum 3.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  upstream 2-bit ripple-carry adder result is present on i_result.
REQ-006 i_result  input  3  adder result {carry, sum[1:0]}, unsigned 0..7.
REQ-007 o_ready  output  1  block accepts i_result this cycle.
REQ-008 i_clear  input  1  synchronous batch abort.
REQ-009 o_sum  output  ACC_WIDTH  completed batch sum.
REQ-010 o_sum_valid  output  1  o_sum holds a completed batch.
REQ-011 i_sum_ack  input  1  downstream has consumed o_sum.
REQ-012 o_overflow  output  1  the batch sum exceeded 2^ACC_WIDTH-1.
REQ-013 o_count  output  8  number of samples accepted in the current batch.

Function
REQ-014 The block SHALL implement two states: ACCUM (collecting samples) and HOLD (presenting a result).
REQ-015 In ACCUM, o_ready SHALL be 1 and o_sum_valid SHALL be 0; in HOLD, o_ready SHALL be 0 and o_sum_valid SHALL be 1.
REQ-016 o_ready SHALL be decoded from registered state only, with no combinational path from any input.
REQ-017 A sample SHALL be accepted only on a rising edge where i_valid=1 and o_ready=1; i_result SHALL be ignored otherwise.
REQ-018 Per accepted sample, acc SHALL become (acc + zero-extended i_result) mod 2^ACC_WIDTH, and o_count SHALL increment by 1.
REQ-019 If that addition produces a carry out of bit ACC_WIDTH-1, o_overflow SHALL be set and SHALL stay set (sticky) until the batch ends.
REQ-020 On acceptance of sample number NUM_SAMPLES, the block SHALL enter HOLD on the same edge, with o_sum = final wrapped acc and o_overflow including that sample's carry.
REQ-021 o_sum_valid SHALL rise in the cycle immediately after the edge that accepted the final sample, giving a latency of 1 cycle.
REQ-022 In HOLD, o_sum, o_overflow and o_count SHALL remain stable until the edge where i_sum_ack=1.
REQ-023 On an i_sum_ack edge in HOLD, the block SHALL return to ACCUM with acc=0, o_count=0 and o_overflow=0.
REQ-024 i_sum_ack in ACCUM SHALL have no effect.
REQ-025 The first new sample SHALL be accepted no earlier than the cycle after the ack.
REQ-026 i_clear=1 at an edge SHALL force ACCUM with acc=0, o_count=0, o_overflow=0 and o_sum=0, in any state.
REQ-027 i_clear SHALL take priority over a simultaneous sample acceptance or i_sum_ack, and that sample SHALL be discarded.
REQ-028 With NUM_SAMPLES=1, every accepted sample SHALL move the block directly to HOLD.
REQ-029 o_sum SHALL read 0 in ACCUM; the running accumulator is internal.

Reset
REQ-030 While i_rst_n=0, the block SHALL hold state ACCUM with acc=0, o_sum=0, o_count=0, o_overflow=0, o_sum_valid=0 and o_ready=1, independent of i_clk.
REQ-031 Reset assertion mid-batch or in HOLD SHALL discard the batch without producing any o_sum_valid pulse.
REQ-032 After deassertion, the first edge with i_valid=1 SHALL be accepted.

Verification (NUM_SAMPLES=4, ACC_WIDTH=8 unless stated)
REQ-033 Basic batch: results 7,7,7,7 on consecutive cycles -> o_sum=28, o_overflow=0, o_count=4, o_sum_valid=1 one cycle after the 4th sample, o_ready=0.
REQ-034 Overflow (ACC_WIDTH=4): results 7,7,7,0 -> o_sum=5, o_overflow=1; after ack, o_overflow=0 and o_count=0.
REQ-035 Backpressure: hold o_sum_valid 5 cycles without ack while driving i_valid=1 with result 3 -> no sample taken and o_sum stable; ack, then 3,3,3,3 -> o_sum=12.
REQ-036 Clear mid-batch: results 5,6, then i_clear=1 coincident with result 7 -> acc=0, o_count=0; then 1,1,1,1 -> o_sum=4.
REQ-037 Gaps and reset: results 2,_,1,_,4 with i_valid low in the gaps, then assert i_rst_n=0 between edges -> immediate o_count=0 and o_ready=1, and no o_sum_valid pulse.
REQ-038 NUM_SAMPLES=1: results 6, ack, 3 -> two o_sum_valid periods with o_sum=6 then o_sum=3.
